// File: rtl/rs_entry_pair.sv
// rs_entry_pair: two-entry reservation station with CDB wakeup and oldest-first issue; CDB_PORT_B_EN adds a second snooped CDB port
module rs_entry_pair #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 4,
  parameter int OP_W  = 81
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  wr_data_0,
  input  logic [TAG_W-1:0] wr_entry_num_0,
  input  logic             wr_valid_0,
  input  logic [OP_W-1:0]  wr_data_1,
  input  logic [TAG_W-1:0] wr_entry_num_1,
  input  logic             wr_valid_1,
  output logic             empty_0,
  output logic             empty_1,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [XLEN-1:0]  cdb_data,
`ifdef CDB_PORT_B_EN
  input  logic             cdb_b_valid,
  input  logic [TAG_W-1:0] cdb_b_tag,
  input  logic [XLEN-1:0]  cdb_b_data,
`endif
  input  logic [TAG_W-1:0] rob_head,
  input  logic             flush,
  output logic             issue_valid,
  input  logic             issue_ready,
  output logic [OP_W-1:0]  issue_data,
  output logic [TAG_W-1:0] issue_rob_tag,
  output logic             protocol_err
);
  logic [OP_W-1:0]  data [2];
  logic [TAG_W-1:0] tag [2];
  logic [OP_W-1:0]  wr_d [2];
  logic [TAG_W-1:0] wr_t [2];
  logic [1:0]       wr_v, occ, rdy;
  logic [TAG_W-1:0] age_0, age_1;
  logic             sel, fire;
  function automatic logic [XLEN:0] snoop(input logic [XLEN:0] s);
    snoop = s;
`ifdef CDB_PORT_B_EN
    if (cdb_b_valid && !s[0] && s[TAG_W:1] == cdb_b_tag) snoop = {cdb_b_data, 1'b1};
`endif
    if (cdb_valid && !s[0] && s[TAG_W:1] == cdb_tag) snoop = {cdb_data, 1'b1};
  endfunction
  function automatic logic [OP_W-1:0] wake(input logic [OP_W-1:0] p);
    wake = {p[80:71], snoop(p[70:38]), snoop(p[37:5]), p[4:0]};
  endfunction
  assign wr_d[0] = wr_data_0;
  assign wr_d[1] = wr_data_1;
  assign wr_t[0] = wr_entry_num_0;
  assign wr_t[1] = wr_entry_num_1;
  assign wr_v = {wr_valid_1, wr_valid_0};
  assign rdy = {occ[1] & data[1][5] & data[1][38], occ[0] & data[0][5] & data[0][38]};
  assign age_0 = tag[0] - rob_head;
  assign age_1 = tag[1] - rob_head;
  always_comb begin
    sel = &rdy ? age_1 < age_0 : rdy[1];
    issue_valid = |rdy;
    fire = issue_valid & issue_ready;
    issue_data = issue_valid ? data[sel] : '0;
    issue_rob_tag = issue_valid ? tag[sel] : '0;
  end
  assign empty_0 = ~occ[0];
  assign empty_1 = ~occ[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      occ <= '0;
      protocol_err <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (flush) occ[i] <= 1'b0;
        else if (wr_v[i] && !occ[i]) begin
          occ[i] <= 1'b1;
          data[i] <= wake(wr_d[i]);
          tag[i] <= wr_t[i];
        end else begin
          if (fire && sel == 1'(i)) occ[i] <= 1'b0;
          if (occ[i]) data[i] <= wake(data[i]);
        end
      end
      if (!flush && |(wr_v & occ)) protocol_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_rs_entry_pair.sv
// tb_rs_entry_pair: directed self-checking bench for rs_entry_pair
module tb_rs_entry_pair;
  logic        clk = 0;
  logic        rst;
  logic [80:0] wr_data_0, wr_data_1;
  logic [3:0]  wr_entry_num_0, wr_entry_num_1;
  logic        wr_valid_0, wr_valid_1;
  logic        empty_0, empty_1;
  logic        cdb_valid;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [3:0]  rob_head;
  logic        flush;
  logic        issue_valid, issue_ready;
  logic [80:0] issue_data;
  logic [3:0]  issue_rob_tag;
  logic        protocol_err;
  int total = 0, bad = 0;
  rs_entry_pair dut (
    .clk(clk), .rst(rst),
    .wr_data_0(wr_data_0), .wr_entry_num_0(wr_entry_num_0), .wr_valid_0(wr_valid_0),
    .wr_data_1(wr_data_1), .wr_entry_num_1(wr_entry_num_1), .wr_valid_1(wr_valid_1),
    .empty_0(empty_0), .empty_1(empty_1),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rob_head(rob_head), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_data(issue_data), .issue_rob_tag(issue_rob_tag),
    .protocol_err(protocol_err)
  );
  always #5 clk = ~clk;
  function automatic logic [80:0] mk(input logic [9:0] c, input logic [31:0] s2, input logic s2v,
                                     input logic [31:0] s1, input logic s1v, input logic [4:0] rd);
    mk = {c, s2, s2v, s1, s1v, rd};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst = 1; flush = 0; wr_valid_0 = 0; wr_valid_1 = 0; wr_data_0 = '0; wr_data_1 = '0;
    wr_entry_num_0 = 0; wr_entry_num_1 = 0; cdb_valid = 0; cdb_tag = 0; cdb_data = 0;
    rob_head = 0; issue_ready = 0;
    tick; tick;
    rst = 0;
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL reset_empty_0 got=%b exp=1", empty_0); end
    total++; if (empty_1 !== 1'b1) begin bad++; $display("FAIL reset_empty_1 got=%b exp=1", empty_1); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid); end
    total++; if (issue_data !== 81'd0) begin bad++; $display("FAIL reset_issue_data got=%h exp=0", issue_data); end
    total++; if (issue_rob_tag !== 4'd0) begin bad++; $display("FAIL reset_issue_tag got=%0d exp=0", issue_rob_tag); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_perr got=%b exp=0", protocol_err); end
  endtask
  task automatic test_basic_issue;
    logic [80:0] p;
    p = mk(10'h2A5, 32'h1111_2222, 1, 32'h3333_4444, 1, 5'd9);
    wr_data_0 = p; wr_entry_num_0 = 3; wr_valid_0 = 1;
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL basic_empty_before got=%b exp=1", empty_0); end
    tick;
    wr_valid_0 = 0;
    total++; if (empty_0 !== 1'b0) begin bad++; $display("FAIL basic_empty_0 got=%b exp=0", empty_0); end
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL basic_issue_valid got=%b exp=1", issue_valid); end
    total++; if (issue_rob_tag !== 4'd3) begin bad++; $display("FAIL basic_tag got=%0d exp=3", issue_rob_tag); end
    total++; if (issue_data !== p) begin bad++; $display("FAIL basic_data got=%h exp=%h", issue_data, p); end
    issue_ready = 1;
    tick;
    issue_ready = 0;
    total++; if (empty_0 !== 1'b1) begin bad++; $display("FAIL basic_freed got=%b exp=1", empty_0); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL basic_idle got=%b exp=0", issue_valid); end
  endtask
  task automatic test_wakeup;
    logic [80:0] exp;
    wr_data_1 = mk(10'h155, 32'hCAFE_0001, 1, 32'h0000_0005, 0, 5'd3);
    wr_entry_num_1 = 6; wr_valid_1 = 1;
    tick;
    wr_valid_1 = 0;
    total++; if (empty_1 !== 1'b0) begin bad++; $display("FAIL wake_empty_1 got=%b exp=0", empty_1); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_not_ready got=%b exp=0", issue_valid); end
    cdb_valid = 1; cdb_tag = 4; cdb_data = 32'h5555_5555;
    tick;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_wrong_tag got=%b exp=0", issue_valid); end
    cdb_tag = 5; cdb_data = 32'hDEAD_BEEF;
    #1;
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL wake_same_cycle got=%b exp=0", issue_valid); end
    tick;
    cdb_valid = 0;
    exp = mk(10'h155, 32'hCAFE_0001, 1, 32'hDEAD_BEEF, 1, 5'd3);
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL wake_ready got=%b exp=1", issue_valid); end
    total++; if (issue_data !== exp) begin bad++; $display("FAIL wake_data got=%h exp=%h", issue_data, exp); end
    total++; if (issue_rob_tag !== 4'd6) begin bad++; $display("FAIL wake_tag got=%0d exp=6", issue_rob_tag); end
    issue_ready = 1;
    tick;
    issue_ready = 0;
    total++; if (empty_1 !== 1'b1) begin bad++; $display("FAIL wake_freed got=%b exp=1", empty_1); end
  endtask
  task automatic test_age;
    logic [80:0] pa, pb;
    pa = mk(10'h001, 32'hA, 1, 32'hB, 1, 5'd1);
    pb = mk(10'h002, 32'hC, 1, 32'hD, 1, 5'd2);
    rob_head = 14;
    wr_data_0 = pa; wr_entry_num_0 = 1; wr_valid_0 = 1;
    wr_data_1 = pb; wr_entry_num_1 = 15; wr_valid_1 = 1;
    tick;
    wr_valid_0 = 0; wr_valid_1 = 0;
    total++; if (issue_rob_tag !== 4'd15) begin bad++; $display("FAIL age_first got=%0d exp=15", issue_rob_tag); end
    total++; if (issue_data !== pb) begin bad++; $display("FAIL age_first_data got=%h exp=%h", issue_data, pb); end
    issue_ready = 1;
    tick;
    total++; if (empty_1 !== 1'b1 || empty_0 !== 1'b0) begin bad++; $display("FAIL age_free_one got=%b%b exp=10", empty_1, empty_0); end
    total++; if (issue_rob_tag !== 4'd1) begin bad++; $display("FAIL age_second got=%0d exp=1", issue_rob_tag); end
    tick;
    issue_ready = 0;
    total++; if (issue_valid !== 1'b0 || empty_0 !== 1'b1) begin bad++; $display("FAIL age_drain got=%b%b exp=01", issue_valid, empty_0); end
    wr_data_0 = pa; wr_entry_num_0 = 4; wr_valid_0 = 1;
    wr_data_1 = pb; wr_entry_num_1 = 4; wr_valid_1 = 1;
    tick;
    wr_valid_0 = 0; wr_valid_1 = 0;
    total++; if (issue_data !== pa) begin bad++; $display("FAIL age_tie got=%h exp=%h", issue_data, pa); end
    issue_ready = 1;
    tick; tick;
    issue_ready = 0;
    rob_head = 0;
  endtask
  task automatic test_write_capture;
    logic [80:0] exp;
    wr_data_0 = mk(10'h3FF, 32'h0000_0007, 0, 32'h8888_0000, 1, 5'd31);
    wr_entry_num_0 = 10; wr_valid_0 = 1;
    cdb_valid = 1; cdb_tag = 7; cdb_data = 32'h1234_5678;
    tick;
    wr_valid_0 = 0; cdb_valid = 0;
    exp = mk(10'h3FF, 32'h1234_5678, 1, 32'h8888_0000, 1, 5'd31);
    total++; if (issue_valid !== 1'b1) begin bad++; $display("FAIL capture_ready got=%b exp=1", issue_valid); end
    total++; if (issue_data !== exp) begin bad++; $display("FAIL capture_data got=%h exp=%h", issue_data, exp); end
    issue_ready = 1;
    tick;
    issue_ready = 0;
  endtask
  task automatic test_stall;
    logic [80:0] p;
    p = mk(10'h0F0, 32'hFFFF_0000, 1, 32'h0000_FFFF, 1, 5'd17);
    wr_data_1 = p; wr_entry_num_1 = 9; wr_valid_1 = 1;
    tick;
    wr_valid_1 = 0;
    for (int k = 0; k < 3; k++) begin
      total++;
      if (issue_valid !== 1'b1 || issue_data !== p || issue_rob_tag !== 4'd9 || empty_1 !== 1'b0) begin
        bad++; $display("FAIL stall_%0d got v=%b tag=%0d e=%b data=%h exp v=1 tag=9 e=0 data=%h", k, issue_valid, issue_rob_tag, empty_1, issue_data, p);
      end
      tick;
    end
    issue_ready = 1;
    tick;
    issue_ready = 0;
    total++; if (empty_1 !== 1'b1 || issue_valid !== 1'b0) begin bad++; $display("FAIL stall_freed got e=%b v=%b exp e=1 v=0", empty_1, issue_valid); end
  endtask
  task automatic test_protocol_flush;
    logic [80:0] pa, pb;
    pa = mk(10'h111, 32'h1, 1, 32'h2, 1, 5'd5);
    pb = mk(10'h222, 32'h3, 1, 32'h4, 1, 5'd6);
    wr_data_0 = pa; wr_entry_num_0 = 2; wr_valid_0 = 1;
    wr_data_1 = pb; wr_entry_num_1 = 3; wr_valid_1 = 1;
    tick;
    wr_valid_1 = 0;
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL perr_clean got=%b exp=0", protocol_err); end
    wr_data_0 = mk(10'h333, 32'h9, 1, 32'h9, 1, 5'd7); wr_entry_num_0 = 8;
    tick;
    wr_valid_0 = 0;
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL perr_set got=%b exp=1", protocol_err); end
    total++; if (issue_data !== pa || issue_rob_tag !== 4'd2) begin bad++; $display("FAIL perr_unchanged got=%h/%0d exp=%h/2", issue_data, issue_rob_tag, pa); end
    flush = 1;
    wr_data_0 = pa; wr_valid_0 = 1;
    tick;
    flush = 0; wr_valid_0 = 0;
    total++; if (empty_0 !== 1'b1 || empty_1 !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b%b exp=11", empty_1, empty_0); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL flush_perr got=%b exp=1", protocol_err); end
    total++; if (issue_valid !== 1'b0) begin bad++; $display("FAIL flush_issue got=%b exp=0", issue_valid); end
  endtask
  task automatic test_mid_reset;
    wr_data_1 = mk(10'h001, 32'h1, 1, 32'h1, 1, 5'd1); wr_entry_num_1 = 12; wr_valid_1 = 1;
    tick;
    wr_valid_1 = 0; issue_ready = 1; rst = 1;
    tick;
    rst = 0; issue_ready = 0;
    total++; if (empty_1 !== 1'b1 || issue_valid !== 1'b0 || protocol_err !== 1'b0 || issue_rob_tag !== 4'd0) begin
      bad++; $display("FAIL mid_reset got e1=%b v=%b perr=%b tag=%0d exp 1/0/0/0", empty_1, issue_valid, protocol_err, issue_rob_tag);
    end
  endtask
  initial begin
    test_reset;
    test_basic_issue;
    test_wakeup;
    test_age;
    test_write_capture;
    test_stall;
    test_protocol_flush;
    test_mid_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/rs_entry_pair.md
Name: rs_entry_pair

Overview:
- Two-entry reservation station bank for one functional-unit class (complex, simple or fp); the receiving end of the dispatch write ports.
- Captures dispatched operations, tracks operand readiness, and snoops the common data bus (CDB) for missing operands.
- Issues the oldest ready operation to its execution unit through a valid/ready handshake.
- Reports per-entry empty bits back to dispatch.

Parameters:
XLEN, 32, operand width
TAG_W, 4, ROB tag width (16-entry ROB)
OP_W, 81, dispatched payload width, excluding dispatch control

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
wr_data_0  input  81  payload for entry 0: {ctrl[80:71], s2[70:39], s2_valid[38], s1[37:6], s1_valid[5], rd[4:0]}
wr_entry_num_0  input  4  ROB tag assigned to entry 0 write
wr_valid_0  input  1  write entry 0 this cycle
wr_data_1  input  81  payload for entry 1
wr_entry_num_1  input  4  ROB tag for entry 1 write
wr_valid_1  input  1  write entry 1 this cycle
empty_0  output  1  entry 0 free
empty_1  output  1  entry 1 free
cdb_valid  input  1  CDB broadcast valid
cdb_tag  input  4  ROB tag of produced result
cdb_data  input  32  result value
rob_head  input  4  ROB head, used for age comparison
flush  input  1  discard all entries
issue_valid  output  1  an entry is ready to execute
issue_ready  input  1  execution unit accepts
issue_data  output  81  payload with resolved operands, both valid bits = 1
issue_rob_tag  output  4  ROB tag of the issued op
protocol_err  output  1  sticky: write to an occupied entry

Behaviour:
- Reset: all entries invalid; empty_0 = empty_1 = 1; issue_valid = 0; issue_data = 0; issue_rob_tag = 0; protocol_err = 0.
- Operand encoding: if s1_valid = 0, s1[3:0] holds the producer ROB tag (same for s2). Upper bits are don't-care.
- Write: wr_valid_x with entry x empty latches payload and tag at the edge; empty_x drops the next cycle.
- Write to an occupied entry: ignored; protocol_err set and held until rst.
- Wakeup: each cycle, for every occupied invalid source with cdb_valid and tag == cdb_tag, load cdb_data into the source field and set its valid bit.
- Same-cycle write + CDB: the incoming write is also compared against the CDB and captures matching data. No tag is lost.
- Ready: entry occupied and s1_valid and s2_valid, evaluated on registered state only. A wakeup makes the entry issuable the following cycle (1-cycle wakeup-to-issue).
- Select: if both entries are ready, issue the older one. Age = (tag - rob_head) mod 16; smaller is older. Ties go to entry 0.
- issue_valid, issue_data and issue_rob_tag are combinational from the registered entries and stable while issue_valid=1 and issue_ready=0.
- On issue_valid & issue_ready: the selected entry is freed at the edge; empty goes to 1 the next cycle. The other entry is unaffected.
- One issue per cycle maximum.
- Freed-then-written: dispatch can only see empty=1 after the free edge, so re-allocation happens at the earliest one cycle after issue.
- flush: all entries invalid at the next edge and empty=1. It overrides same-cycle writes and wakeups. issue_valid is still combinational that cycle and issues nothing after the edge. protocol_err is unchanged.
- rst mid-operation: same as the reset state regardless of pending handshakes.
- Tags compare modulo 16; the age subtraction wraps at 4 bits.

Optional Feature:
CDB_PORT_B_EN
- Defined: adds inputs cdb_b_valid (1), cdb_b_tag (4) and cdb_b_data (32). Both CDB ports are snooped in parallel with identical rules, including the same-cycle-write capture.
- If both ports match one source, port A wins (the ROB guarantees this cannot legally happen).
- Undefined: the ports are absent and only the single CDB is snooped.

Test Plan:
1. Reset, then write entry 0 with both sources valid (tag 3) -> empty_0=0 next cycle; issue_valid=1 and issue_rob_tag=3. With issue_ready=1 -> empty_0=1 the following cycle.
2. Entry 1 with s1_valid=0 and s1[3:0]=5; CDB tag 5, data 0xDEADBEEF -> issue_valid one cycle later; issue_data s1 field=0xDEADBEEF and s1_valid=1.
3. rob_head=14; entry 0 tag 1 and entry 1 tag 15, both ready -> tag 15 issues first, then tag 1.
4. Write entry 0 waiting on tag 7 while CDB broadcasts tag 7 in the same cycle -> entry ready next cycle with the captured data.
5. issue_ready=0 for 3 cycles with an entry ready -> issue_data and issue_rob_tag are stable; entry freed only after the accept cycle.
6. Both entries full, wr_valid_0=1 -> protocol_err=1 and entry 0 contents unchanged. Then flush=1 -> empty_0 = empty_1 = 1 next cycle and protocol_err stays 1.
